konverter_burst_ctrl: RTL
=========================

Name: konverter_burst_ctrl

Overview:
- Synchronous sequencer for the two serial converter channels.
- A falling edge on frame sync f0 arms the frame; each falling edge of c4 starts a burst of BURST_LEN gated bit-clock pulses, first on channel 1 and then on channel 2.
- Replaces delay-based pulse generation with a counter/FSM in the system clock domain. Sits between the frame-timing inputs and the per-channel shift logic.

Parameters:
- BURST_LEN, 32, bit-clock pulses per channel burst (1..63).
- HALF_PER, 2, clk cycles per high phase and per low phase of clk1/clk2 (>=1).
- CNT_W, 6, width of the pulse counter; must hold BURST_LEN.

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset  input  1  asynchronous active-high reset.
- f0  input  1  frame sync, asynchronous to clk, active falling edge.
- c4  input  1  bit-timing reference, asynchronous to clk, active falling edge.
- ch_en  input  2  channel enables: bit0 = channel 1, bit1 = channel 2.
- clk_en1  output  1  channel 1 burst window.
- clk_en2  output  1  channel 2 burst window.
- clk1  output  1  channel 1 gated bit clock.
- clk2  output  1  channel 2 gated bit clock.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse when a frame sequence completes.
- frame_err  output  1  one-cycle pulse when f0 falls while busy.

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0; counters and synchronizers cleared (synchronizer flops reset to 1).
- Input sync: f0 and c4 each pass through a 2-flop synchronizer plus a history flop.
  - f0_fall / c4_fall = history 1 and stage2 0; one-cycle pulses.
  - Pin-to-pulse latency is 2-3 clk cycles.
- ch_en is latched into en_q on f0_fall in IDLE and held for the whole frame.
- FSM states: IDLE, ARM1, BURST1, ARM2, BURST2.
- IDLE:
  - f0_fall with ch_en[0]=1 -> ARM1, clk_en1<=1.
  - Else f0_fall with ch_en[1]=1 -> ARM2, clk_en2<=1.
  - Else f0_fall with ch_en=0 -> stay in IDLE; no done, no error.
- ARM1: wait for c4_fall -> BURST1, phase counter and pulse counter cleared. clk1=1 from the cycle after c4_fall is detected.
- BURST1:
  - clk1 high for HALF_PER cycles, then low for HALF_PER cycles; each full high+low counts as one pulse.
  - At the end of the low phase of pulse BURST_LEN, clk_en1<=0 on the same edge.
  - Then if en_q[1]=1 -> ARM2 with clk_en2<=1; else -> IDLE with done<=1.
  - Window length from first clk1 high: exactly 2*HALF_PER*BURST_LEN cycles.
- ARM2 / BURST2: identical behaviour on clk2/clk_en2. On completion -> IDLE, done<=1.
- Channel 2 never starts on the c4_fall that started channel 1; it needs a new c4_fall detected in ARM2.
- c4_fall during BURST1/BURST2 is ignored. c4_fall in IDLE is ignored.
- f0_fall while busy: frame_err pulses 1 cycle; the sequence continues unchanged; that f0 is not queued.
- clk1/clk2 are 0 whenever their clk_en is 0. Both channels are never enabled simultaneously.
- busy is a registered decode of state (0 in IDLE).

Test Plan:
- Reset check: assert reset mid-BURST1 (after pulse 10) -> all outputs 0 in the same cycle, FSM returns to IDLE; after release, the next f0 fall starts cleanly.
- Single channel: ch_en=01, f0 fall, then c4 fall -> clk_en1 high from f0 detect; exactly 32 clk1 pulses, each 2 high/2 low; clk_en1 low after 128 cycles; done pulses once; clk2/clk_en2 stay 0.
- Dual channel: ch_en=11 -> 32 pulses on clk1, clk_en2 rises the cycle clk_en1 falls, wait for next c4 fall, 32 pulses on clk2, done after clk_en2 falls. Count each channel independently.
- Channel 2 only: ch_en=10, f0 fall -> FSM goes IDLE->ARM2 directly; clk1 never toggles; 32 clk2 pulses; done pulses once.
- Frame error: second f0 fall during BURST1 pulse 5 -> frame_err one cycle; pulse count still 32; no extra burst afterwards.
- Parameter sweep: BURST_LEN=1/HALF_PER=1 and BURST_LEN=63/HALF_PER=3 -> window of 2 and 378 cycles respectively; ch_en=00 with f0 fall -> no activity, done=0.

Source files
------------

// File: rtl/konverter_burst_ctrl_if.sv
// Pin bundle between the frame-timing inputs, the burst sequencer and the per-channel shift logic.
// f0/c4 are free-running asynchronous level pins. There is no valid/ready handshake on this
// bundle: the sequencer acts only on falling edges it detects after synchronisation.
interface konverter_burst_ctrl_if;
    logic       f0;
    logic       c4;
    logic [1:0] ch_en;
    logic       clk_en1;
    logic       clk_en2;
    logic       clk1;
    logic       clk2;
    logic       busy;
    logic       done;
    logic       frame_err;
    logic [2:0] dbg_state;

    modport slave (
        input  f0, c4, ch_en,
        output clk_en1, clk_en2, clk1, clk2, busy, done, frame_err, dbg_state
    );

    modport master (
        output f0, c4, ch_en,
        input  clk_en1, clk_en2, clk1, clk2, busy, done, frame_err, dbg_state
    );
endinterface

// File: rtl/konverter_burst_ctrl.sv
// Frame sequencer: f0 fall arms a frame, each c4 fall fires a BURST_LEN-pulse gated bit clock,
// channel 1 first, then channel 2. All timing is counted in the system clock domain.
module konverter_burst_ctrl #(
    parameter int BURST_LEN = 32,
    parameter int HALF_PER  = 2,
    parameter int CNT_W     = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    konverter_burst_ctrl_if.slave bus
);
    localparam int PH_W = (HALF_PER > 1) ? $clog2(HALF_PER) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM1   = 3'd1,
        S_BURST1 = 3'd2,
        S_ARM2   = 3'd3,
        S_BURST2 = 3'd4
    } state_t;

    logic             r_f0_s1, r_f0_s2, r_f0_h;
    logic             r_c4_s1, r_c4_s2, r_c4_h;
    state_t           r_state;
    logic [1:0]       r_en_q;
    logic [PH_W-1:0]  r_phase;
    logic [CNT_W-1:0] r_pulse;
    logic             r_clk_en1, r_clk_en2, r_clk1, r_clk2;
    logic             r_busy, r_done, r_frame_err;

    logic w_f0_fall, w_c4_fall, w_phase_end, w_last_pulse;

    // Synchronisers idle high so a released reset never looks like a falling edge on a high pin.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_f0_s1 <= 1'b1;
            r_f0_s2 <= 1'b1;
            r_f0_h  <= 1'b1;
            r_c4_s1 <= 1'b1;
            r_c4_s2 <= 1'b1;
            r_c4_h  <= 1'b1;
        end else begin
            r_f0_s1 <= bus.f0;
            r_f0_s2 <= r_f0_s1;
            r_f0_h  <= r_f0_s2;
            r_c4_s1 <= bus.c4;
            r_c4_s2 <= r_c4_s1;
            r_c4_h  <= r_c4_s2;
        end
    end

    assign w_f0_fall    = r_f0_h & ~r_f0_s2;
    assign w_c4_fall    = r_c4_h & ~r_c4_s2;
    assign w_phase_end  = (r_phase == PH_W'(HALF_PER - 1));
    assign w_last_pulse = (r_pulse == CNT_W'(BURST_LEN - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_en_q      <= 2'b00;
            r_phase     <= '0;
            r_pulse     <= '0;
            r_clk_en1   <= 1'b0;
            r_clk_en2   <= 1'b0;
            r_clk1      <= 1'b0;
            r_clk2      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_frame_err <= w_f0_fall && (r_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (w_f0_fall) begin
                        r_en_q <= bus.ch_en;
                        if (bus.ch_en[0]) begin
                            r_state   <= S_ARM1;
                            r_clk_en1 <= 1'b1;
                            r_busy    <= 1'b1;
                        end else if (bus.ch_en[1]) begin
                            r_state   <= S_ARM2;
                            r_clk_en2 <= 1'b1;
                            r_busy    <= 1'b1;
                        end
                    end
                end
                S_ARM1: begin
                    if (w_c4_fall) begin
                        r_state <= S_BURST1;
                        r_phase <= '0;
                        r_pulse <= '0;
                        r_clk1  <= 1'b1;
                    end
                end
                S_BURST1: begin
                    if (!w_phase_end) begin
                        r_phase <= r_phase + 1'b1;
                    end else begin
                        r_phase <= '0;
                        if (r_clk1) begin
                            r_clk1 <= 1'b0;
                        end else if (!w_last_pulse) begin
                            r_pulse <= r_pulse + 1'b1;
                            r_clk1  <= 1'b1;
                        end else begin
                            // Channel 2 still has to wait for its own c4 fall in ARM2.
                            r_clk_en1 <= 1'b0;
                            if (r_en_q[1]) begin
                                r_state   <= S_ARM2;
                                r_clk_en2 <= 1'b1;
                            end else begin
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                end
                S_ARM2: begin
                    if (w_c4_fall) begin
                        r_state <= S_BURST2;
                        r_phase <= '0;
                        r_pulse <= '0;
                        r_clk2  <= 1'b1;
                    end
                end
                S_BURST2: begin
                    if (!w_phase_end) begin
                        r_phase <= r_phase + 1'b1;
                    end else begin
                        r_phase <= '0;
                        if (r_clk2) begin
                            r_clk2 <= 1'b0;
                        end else if (!w_last_pulse) begin
                            r_pulse <= r_pulse + 1'b1;
                            r_clk2  <= 1'b1;
                        end else begin
                            r_clk_en2 <= 1'b0;
                            r_state   <= S_IDLE;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_clk_en1 <= 1'b0;
                    r_clk_en2 <= 1'b0;
                    r_clk1    <= 1'b0;
                    r_clk2    <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.clk_en1   = r_clk_en1;
    assign bus.clk_en2   = r_clk_en2;
    assign bus.clk1      = r_clk1;
    assign bus.clk2      = r_clk2;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.frame_err = r_frame_err;
    assign bus.dbg_state = r_state;
endmodule
